// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the fpg8 control path: opcodes, ALU operations,
// register-file selects and sequencer states.
package fpg8_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_MOV   = 4'h4,
        OP_LOAD  = 4'h5,
        OP_STORE = 4'h6,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_PASS_A = 3'b000,
        ALU_ADD    = 3'b001,
        ALU_SUB    = 3'b010,
        ALU_AND    = 3'b011,
        ALU_INC    = 3'b100
    } alu_op_t;

    typedef enum logic [2:0] {
        SEL_R0  = 3'b000,
        SEL_PC  = 3'b001,
        SEL_RD1 = 3'b010,
        SEL_RD2 = 3'b011,
        SEL_RS1 = 3'b100,
        SEL_RS2 = 3'b101
    } gpr_sel_t;

    typedef enum logic [3:0] {
        ST_FETCH_ADDR,
        ST_FETCH_WAIT,
        ST_PC_INC,
        ST_DECODE,
        ST_EX_A,
        ST_EX_B,
        ST_EX_WB,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_HALT
    } state_t;

endpackage

// File: rtl/control_sequencer_instr_reg.sv
// Instruction register: captures the bus word on load and splits it into
// opcode and the four 3-bit register fields.
module instr_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] data,
    output logic [3:0]  opcode,
    output logic [2:0]  rd_1,
    output logic [2:0]  rs_1,
    output logic [2:0]  rs_2,
    output logic [2:0]  rd_2
);

    logic [15:0] ir;

    always_ff @(posedge clk) begin
        if (reset) begin
            ir <= '0;
        end else if (load) begin
            ir <= data;
        end
    end

    assign opcode = ir[15:12];
    assign rd_1   = ir[11:9];
    assign rs_1   = ir[8:6];
    assign rs_2   = ir[5:3];
    assign rd_2   = ir[2:0];

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetches an instruction word from the shared
// bus, then steps through register/ALU/memory transfer states.
module control_sequencer
    import fpg8_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] DATA,
    input  logic        MEM_ready,
    output logic        GPR_in,
    output logic        GPR_out,
    output logic [2:0]  GPR_select,
    output logic [2:0]  Rd_1,
    output logic [2:0]  Rs_1,
    output logic [2:0]  Rs_2,
    output logic [2:0]  Rd_2,
    output logic        MAR_in,
    output logic        MEM_rd,
    output logic        MEM_wr,
    output logic        ALU_A_in,
    output logic        ALU_B_in,
    output logic        ALU_out,
    output logic [2:0]  ALU_op,
    output logic        HALTED,
    output logic        ILLEGAL
);

    state_t     state;
    logic [3:0] opcode;
    opcode_t    op;
    logic       ir_load;
    alu_op_t    alu_op;
    gpr_sel_t   gpr_sel;

    assign ir_load = (state == ST_FETCH_WAIT) && MEM_ready;
    assign op      = opcode_t'(opcode);

    instr_reg u_instr_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (ir_load),
        .data   (DATA),
        .opcode (opcode),
        .rd_1   (Rd_1),
        .rs_1   (Rs_1),
        .rs_2   (Rs_2),
        .rd_2   (Rd_2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH_ADDR;
        end else begin
            case (state)
                ST_FETCH_ADDR: state <= ST_FETCH_WAIT;
                ST_FETCH_WAIT: if (MEM_ready) state <= ST_PC_INC;
                ST_PC_INC:     state <= ST_DECODE;
                ST_DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_MOV: state <= ST_EX_A;
                        OP_LOAD, OP_STORE:              state <= ST_MEM_ADDR;
                        OP_HALT:                        state <= ST_HALT;
                        default:                        state <= ST_FETCH_ADDR;
                    endcase
                end
                ST_EX_A:     state <= (op == OP_MOV) ? ST_EX_WB : ST_EX_B;
                ST_EX_B:     state <= ST_EX_WB;
                ST_EX_WB:    state <= ST_FETCH_ADDR;
                ST_MEM_ADDR: state <= (op == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
                ST_MEM_RD:   if (MEM_ready) state <= ST_FETCH_ADDR;
                ST_MEM_WR:   if (MEM_ready) state <= ST_FETCH_ADDR;
                ST_HALT:     state <= ST_HALT;
                default:     state <= ST_FETCH_ADDR;
            endcase
        end
    end

    always_comb begin
        GPR_in   = 1'b0;
        GPR_out  = 1'b0;
        gpr_sel  = SEL_R0;
        MAR_in   = 1'b0;
        MEM_rd   = 1'b0;
        MEM_wr   = 1'b0;
        ALU_A_in = 1'b0;
        ALU_B_in = 1'b0;
        ALU_out  = 1'b0;
        alu_op   = ALU_PASS_A;
        HALTED   = 1'b0;
        ILLEGAL  = 1'b0;
        case (state)
            ST_FETCH_ADDR: begin
                GPR_out  = 1'b1;
                gpr_sel  = SEL_PC;
                MAR_in   = 1'b1;
                ALU_A_in = 1'b1;
            end
            ST_FETCH_WAIT: MEM_rd = 1'b1;
            ST_PC_INC: begin
                alu_op  = ALU_INC;
                ALU_out = 1'b1;
                GPR_in  = 1'b1;
                gpr_sel = SEL_PC;
            end
            ST_DECODE: begin
                case (op)
                    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_MOV,
                    OP_LOAD, OP_STORE, OP_HALT: ILLEGAL = 1'b0;
                    default:                    ILLEGAL = 1'b1;
                endcase
            end
            ST_EX_A: begin
                GPR_out  = 1'b1;
                gpr_sel  = SEL_RS1;
                ALU_A_in = 1'b1;
            end
            ST_EX_B: begin
                GPR_out  = 1'b1;
                gpr_sel  = SEL_RS2;
                ALU_B_in = 1'b1;
            end
            ST_EX_WB: begin
                ALU_out = 1'b1;
                GPR_in  = 1'b1;
                gpr_sel = SEL_RD1;
                case (op)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_AND:  alu_op = ALU_AND;
                    default: alu_op = ALU_PASS_A;
                endcase
            end
            ST_MEM_ADDR: begin
                GPR_out = 1'b1;
                gpr_sel = SEL_RS1;
                MAR_in  = 1'b1;
            end
            ST_MEM_RD: begin
                MEM_rd  = 1'b1;
                gpr_sel = SEL_RD1;
                GPR_in  = MEM_ready;
            end
            ST_MEM_WR: begin
                MEM_wr  = 1'b1;
                GPR_out = 1'b1;
                gpr_sel = SEL_RS2;
            end
            ST_HALT: HALTED = 1'b1;
            default: ;
        endcase
        // Reset silences every strobe at once; the state register itself only
        // changes on the clock edge, so FETCH_ADDR shows as soon as reset drops.
        if (reset) begin
            GPR_in   = 1'b0;
            GPR_out  = 1'b0;
            gpr_sel  = SEL_R0;
            MAR_in   = 1'b0;
            MEM_rd   = 1'b0;
            MEM_wr   = 1'b0;
            ALU_A_in = 1'b0;
            ALU_B_in = 1'b0;
            ALU_out  = 1'b0;
            alu_op   = ALU_PASS_A;
            HALTED   = 1'b0;
            ILLEGAL  = 1'b0;
        end
    end

    assign GPR_select = gpr_sel;
    assign ALU_op     = alu_op;

endmodule
